// File: rtl/apb_mem_responder_if.sv
// APB3 bus bundle shared by the team's APB master and apb_mem_responder.
//   psel/penable/pwrite/paddr/pwdata : master -> completer
//   prdata/pready/pslverr            : completer -> master (zero when not addressed)
interface apb_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [15:0]       paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_responder.sv
// APB3 completer exposing a DEPTH-word memory window on page `id`
// (paddr[15:8]), with WAIT_CYCLES extra access cycles and PSLVERR for
// out-of-range or misaligned addresses. Bus outputs are zero when the
// block is not addressed so several instances can be OR-combined.
// Ports:
//   clk      : bus clock, rising edge
//   rst_n    : asynchronous active-low reset (clears memory)
//   id       : page ID compared against paddr[15:8]
//   apb      : APB3 slave modport (psel/penable/pwrite/paddr/pwdata in,
//              prdata/pready/pslverr out)
//   wr_pulse : one-cycle pulse in the cycle after a write commits
//   wr_index : word index of the last committed write
module apb_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            id,
  apb_mem_responder_if.slave    apb,
  output logic                  wr_pulse,
  output logic [5:0]            wr_index
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;

  logic [7:0]        r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_pulse;
  logic [5:0]        r_wr_index;

  logic              w_hit;
  logic              w_busy;
  logic              w_ready;
  logic              w_done;
  logic              w_err;
  logic              w_wr_ok;
  logic              w_latch;
  logic [5:0]        w_word;
  logic [IDX_W-1:0]  w_idx;

  assign w_hit   = apb.psel && (apb.paddr[15:8] == id);
  assign w_word  = r_addr[7:2];
  assign w_idx   = r_addr[2 +: IDX_W];
  assign w_err   = ({1'b0, w_word} >= DEPTH_L) || (r_addr[1:0] != 2'b00);
  assign w_busy  = (r_state != ST_IDLE);
  // The FSM lags the bus by one cycle: ST_SETUP is entered on the edge
  // that closes the bus SETUP phase, so it coincides with the first
  // ACCESS-phase cycle. This keeps the transfer at 2+WAIT_CYCLES cycles.
  assign w_ready = w_hit && w_busy && (r_cnt == '0);
  assign w_done  = w_ready && ((r_state == ST_ACCESS) || apb.penable);
  assign w_wr_ok = w_done && r_write && !w_err;
  assign w_latch = (r_state == ST_IDLE) && w_hit && !apb.penable;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_hit && !apb.penable) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      ST_SETUP: begin
        if (w_hit && apb.penable) begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ACCESS;
            w_cnt_nxt   = r_cnt - 4'd1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!w_hit || (r_cnt == '0)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    apb.pready  = w_ready;
    apb.pslverr = w_ready && w_err;
    apb.prdata  = (w_ready && !r_write && !w_err) ? r_mem[w_idx] : '0;
    wr_pulse    = r_wr_pulse;
    wr_index    = r_wr_index;
  end

  // Transfer attributes captured in the SETUP phase; later bus changes ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_addr  <= apb.paddr[7:0];
      r_write <= apb.pwrite;
      r_wdata <= apb.pwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_wr_pulse <= w_wr_ok;
      if (w_wr_ok) begin
        r_mem[w_idx] <= r_wdata;
        r_wr_index   <= w_word;
      end
    end
  end

endmodule

// File: doc/apb_mem_responder.md
Name: apb_mem_responder

Overview:
- APB3 completer (responder) answering transfers issued by the team's APB master on the shared APB bus.
- Provides a DEPTH-word register/memory window, page-decoded by the 8-bit `id` input, with programmable wait states and PSLVERR on bad accesses.
- Outputs are zero when the block is not addressed, so several instances can be OR-combined on one bus.
- A write-commit pulse gives the I2C-side logic a notification hook.

Parameters:
- DATA_W, 32, data bus width.
- DEPTH, 16, number of words; must be ≤ 64.
- WAIT_CYCLES, 1, extra ACCESS cycles before PREADY (0–15).

Ports:
- clk  input  1  bus clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id  input  8  page ID; the block is addressed when paddr[15:8]==id.
- psel  input  1  APB select.
- penable  input  1  APB enable (ACCESS phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  16  byte address; [7:2] word index, [1:0] must be 0.
- pwdata  input  DATA_W  write data.
- prdata  output  DATA_W  read data; valid only when pready=1 and pwrite=0.
- pready  output  1  transfer completes this cycle.
- pslverr  output  1  error response; valid only with pready=1.
- wr_pulse  output  1  one-cycle pulse when a write commits.
- wr_index  output  6  word index of the last committed write.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All memory words cleared to 0.
  - prdata, pready, pslverr, wr_pulse = 0; wr_index = 0.
  - FSM forced to IDLE and wait counter = 0.
  - Reset asserted mid-transfer aborts it with no write.
- Hit: `hit = psel && paddr[15:8]==id`. When hit is 0, the block drives pready, pslverr and prdata to 0 and does not change state.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - hit && !penable → SETUP.
  - Latch paddr[7:0], pwrite and pwdata into internal registers.
  - Load the wait counter with WAIT_CYCLES.
- SETUP: lasts one cycle. hit && penable → ACCESS. Any other input → IDLE with no effect (protocol violation is ignored).
- ACCESS:
  - pready = 1 when counter==0; otherwise the counter decrements each cycle and pready = 0.
  - pready is decoded from registered state and counter, with no combinational path from inputs except the hit gating.
  - Total transfer is 2+WAIT_CYCLES cycles, from the SETUP cycle through the completing cycle inclusive.
- Error condition (evaluated on the latched address): index ≥ DEPTH, or paddr[1:0] != 0.
  - On error: pslverr=1 in the pready cycle, memory unchanged, prdata=0, no wr_pulse.
- Read: prdata = mem[index] in the pready cycle, and 0 in every other cycle.
- Write:
  - mem[index] ← latched pwdata at the rising edge ending the pready cycle.
  - wr_pulse=1 and wr_index updated in the following cycle.
- After the pready cycle:
  - hit && !penable → SETUP (back-to-back transfer with no idle cycle).
  - Otherwise → IDLE.
- psel dropped or id mismatch during ACCESS before pready:
  - Abort to IDLE, no write, no wr_pulse.
  - Outputs go to 0 in the same cycle.
- Changes to paddr or pwdata during ACCESS are ignored; the latched SETUP values are used.
- A read in the cycle after a write to the same index returns the new data.

Test Plan:
- Reset/defaults: hold rst_n=0 for 3 cycles → prdata=0, pready=0, pslverr=0. A read of index 5 with id=0x12, paddr=0x1214 then returns 0x00000000.
- Write/read, WAIT_CYCLES=1, id=0x12:
  - Write 0xDEADBEEF to paddr=0x1208 → pready low for the 1st ACCESS cycle and high for the 2nd.
  - wr_pulse the next cycle with wr_index=2.
  - Read of 0x1208 → prdata=0xDEADBEEF, pslverr=0.
- Errors:
  - Write to 0x1240 (index 16 ≥ DEPTH) → pready=1, pslverr=1 after the wait, no wr_pulse.
  - Write to 0x1209 (misaligned) → pslverr=1.
  - A subsequent read of index 2 still returns 0xDEADBEEF.
- Page miss: transfers to 0x3408 with id=0x12 → pready, prdata and pslverr stay 0 for 10 cycles and memory is unchanged.
- Back-to-back and zero-wait, WAIT_CYCLES=0:
  - Write 0x1 to index 0, then read index 0 with no idle cycle → each transfer is 2 cycles.
  - The read returns 0x00000001.
- Abort and async reset:
  - With WAIT_CYCLES=3, drop psel in the 2nd ACCESS cycle of a write of 0xA5A5A5A5 to index 1 → no write, index 1 reads 0.
  - Assert rst_n low mid-ACCESS between clock edges → outputs go to 0 immediately and FSM returns to IDLE.
